// File: rtl/cpu_frame_sched_pkg.sv
// Shared types and constants for the CPU frame scheduler.
// Latency: none (types and pure functions only).
// Backpressure: none.
`ifndef WAIT
`define WAIT 5'h1E
`endif
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 12
`endif

package cpu_frame_sched_pkg;

  localparam int DATA_ADDR_WIDTH = `DATA_ADDR_WIDTH;
  localparam logic [4:0] WAIT_OP = `WAIT;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_WAITING = 3'd2,
    ST_RESUME  = 3'd3
  } sched_state_t;

  // Operates on instruction[15:10]: WAIT is a short-format word (bit 15 clear)
  // whose opcode field is the WAIT opcode.
  function automatic logic is_wait_op(input logic [5:0] hi);
    return (hi[5] == 1'b0) && (hi[4:0] == WAIT_OP);
  endfunction

endpackage

// File: rtl/cpu_frame_sched_if.sv
// Copy-engine handshake onto the shared data-memory read port.
// Latency: grant follows request by one cycle; release follows done by one cycle.
// Backpressure: the engine holds req until granted; it owns the port only while gnt.
interface cpu_frame_sched_if
  import cpu_frame_sched_pkg::*;
#(
  parameter int AW = DATA_ADDR_WIDTH
);
  logic          req;
  logic          gnt;
  logic          done;
  logic [AW-1:0] addr;

  modport master (output req, output done, output addr, input gnt);
  modport slave  (input req, input done, input addr, output gnt);
endinterface

// File: rtl/cpu_frame_sched_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
// Latency: count updates on the edge after inc.
// Backpressure: none; increments at saturation are dropped.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up until all-ones, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_frame_sched.sv
// Frame sequencer: holds/releases CPU reset, parks CPU on WAIT, resumes once per frame.
// Latency: frame_start to cpu_resume is 2 cycles when parked and the port is idle.
// Backpressure: a granted copy blocks resume until copy_done and copy_req low.
module cpu_frame_sched
  import cpu_frame_sched_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DATA_ADDR_WIDTH,
  parameter int                    RESET_CYCLES = 4,
  parameter int                    WDOG_WIDTH   = 20,
  parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT   = '1,
  parameter int                    CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic [15:0]           instruction,
  output logic                  cpu_reset,
  output logic                  cpu_resume,
  input  logic [DATA_WIDTH-1:0] cpu_mem_addr,
  output logic [DATA_WIDTH-1:0] mem_addr,
  cpu_frame_sched_if.slave      copy,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  overrun_cnt,
  output logic [CNT_WIDTH-1:0]  wdog_cnt,
  output logic [2:0]            state_o
);

  localparam int              HCW       = $clog2(RESET_CYCLES + 1);
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(RESET_CYCLES - 1);

  sched_state_t          state, state_d;
  logic [HCW-1:0]        hold_cnt;
  logic [WDOG_WIDTH-1:0] wdog;
  logic [WDOG_WIDTH-1:0] wdog_next;
  logic                  frame_pending;
  logic                  copy_gnt;
  logic                  is_wait;
  logic                  frame_in;
  logic                  overrun_evt;
  logic                  wdog_trip;
  logic                  unused_instr;

  // Only the opcode bits of the fetched word matter for WAIT detection.
  assign unused_instr = &{1'b0, instruction[9:0]};
  assign is_wait      = is_wait_op(instruction[15:10]);

  // Frames are dropped while the CPU is held; a second frame before resume is an overrun.
  assign frame_in    = frame_start && (state != ST_HOLD);
  assign overrun_evt = frame_in && ((state == ST_RUN) || frame_pending);

  // WAIT in the same cycle as the limit wins over the trip.
  assign wdog_next = wdog + 1'b1;
  assign wdog_trip = (state == ST_RUN) && !is_wait && (wdog_next == WDOG_LIMIT);

  assign cpu_reset  = (state == ST_HOLD);
  assign cpu_resume = (state == ST_RESUME);
  assign copy.gnt   = copy_gnt;
  assign mem_addr   = copy_gnt ? copy.addr : cpu_mem_addr;
  assign state_o    = state;

  // Next-state selection.
  always_comb begin
    state_d = state;
    case (state)
      ST_HOLD:    if (hold_cnt == HOLD_LAST) state_d = ST_RUN;
      ST_RUN: begin
        if (is_wait)        state_d = ST_WAITING;
        else if (wdog_trip) state_d = ST_HOLD;
      end
      ST_WAITING: if (frame_pending && !copy_gnt && !copy.req) state_d = ST_RESUME;
      ST_RESUME:  state_d = ST_RUN;
      default:    state_d = ST_HOLD;
    endcase
  end

  // State register plus the reset-hold and run watchdog counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      wdog     <= '0;
    end else begin
      state    <= state_d;
      hold_cnt <= ((state == ST_HOLD) && (state_d == ST_HOLD)) ? hold_cnt + 1'b1 : '0;
      wdog     <= ((state == ST_RUN) && (state_d == ST_RUN)) ? wdog_next : '0;
    end
  end

  // Pending-frame flag, sticky overrun and the copy grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_pending <= 1'b0;
      overrun       <= 1'b0;
      copy_gnt      <= 1'b0;
    end else begin
      if (wdog_trip || (state == ST_RESUME)) frame_pending <= 1'b0;
      else if (frame_in)                     frame_pending <= 1'b1;

      if (overrun_evt) overrun <= 1'b1;

      if (state != ST_WAITING)          copy_gnt <= 1'b0;
      else if (copy_gnt && copy.done)   copy_gnt <= 1'b0;
      else if (!copy_gnt && copy.req)   copy_gnt <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_overrun_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (overrun_evt),
    .count (overrun_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wdog_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (wdog_trip),
    .count (wdog_cnt)
  );

endmodule

// File: doc/cpu_frame_sched.md
Name: cpu_frame_sched

Overview:
- Frame-level sequencer for the single-cycle CPU.
- Holds the CPU in reset after power-up and releases it. Detects the WAIT instruction on the fetch bus and issues one resume pulse per frame_start (vsync) event.
- While the CPU is parked, grants the data-memory read port to a copy engine (frame snapshot for the GPU). Also provides a run-time watchdog and overrun/watchdog statistics.

Parameters:
- DATA_WIDTH, `DATA_ADDR_WIDTH, data memory address width
- RESET_CYCLES, 4, cycles cpu_reset is held after reset release or watchdog trip (>=1)
- WDOG_WIDTH, 20, width of run-cycle watchdog counter
- WDOG_LIMIT, 20'hF_FFFF, RUN cycles allowed before watchdog trip (>=1)
- CNT_WIDTH, 8, width of the overrun and watchdog event counters

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of frame (vsync)
- instruction  in  16  instruction word presented to the CPU (same bus the CPU sees)
- cpu_reset  out  1  drives CPU reset
- cpu_resume  out  1  drives CPU resume, one-cycle pulse
- cpu_mem_addr  in  DATA_WIDTH  CPU data-memory read address
- copy_mem_addr  in  DATA_WIDTH  copy-engine read address
- mem_addr  out  DATA_WIDTH  address to data memory read port
- copy_req  in  1  copy engine requests the memory port
- copy_gnt  out  1  grant; copy engine owns the port while high
- copy_done  in  1  one-cycle pulse, copy engine finished; valid only while copy_gnt
- overrun  out  1  sticky: frame_start arrived while the CPU was running
- overrun_cnt  out  CNT_WIDTH  saturating count of overruns
- wdog_cnt  out  CNT_WIDTH  saturating count of watchdog trips
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (reset_n low, async): state=HOLD, hold counter=0.
  - cpu_reset=1, cpu_resume=0, copy_gnt=0.
  - overrun=0, both counters=0, frame_pending=0.
- WAIT detect (combinational): is_wait = instruction[15]==0 && instruction[14:10]==`WAIT.
- HOLD:
  - cpu_reset=1 for exactly RESET_CYCLES cycles after reset_n deasserts, then go to RUN.
  - cpu_reset deasserts in the same cycle the state becomes RUN.
- RUN:
  - cpu_reset=0; mem_addr=cpu_mem_addr; watchdog counter increments every cycle.
  - is_wait -> WAITING on the next cycle; the CPU sets its wait flag in that same edge. Watchdog counter clears.
  - Watchdog counter reaching WDOG_LIMIT -> HOLD. wdog_cnt += 1 (saturating), frame_pending cleared, full RESET_CYCLES hold.
- WAITING:
  - Entered with frame_pending already 1 and no copy active -> RESUME on the next cycle.
  - Otherwise: copy_req and no grant -> assert copy_gnt on the next cycle. mem_addr=copy_mem_addr whenever copy_gnt=1.
  - copy_done -> copy_gnt drops on the next cycle.
  - Exit to RESUME when frame_pending==1 and copy_gnt==0 and copy_req==0. A frame never interrupts an in-progress copy.
- RESUME:
  - cpu_resume=1 for exactly one cycle; frame_pending cleared; next state RUN.
  - is_wait is ignored in this cycle, because the WAIT word is still on the bus.
- frame_start handling:
  - Sets frame_pending in any state except HOLD, where it is dropped.
  - Arriving in RUN, or while frame_pending is already 1: overrun=1 (sticky until reset) and overrun_cnt += 1, saturating at all-ones. The resume still happens once the CPU reaches WAIT; the extra frame is not queued.
- Simultaneous events:
  - frame_start and is_wait in the same RUN cycle counts as an overrun. Result: WAITING with frame_pending=1, then RESUME one cycle later.
  - Watchdog trip and is_wait in the same cycle: WAIT wins, no trip.
  - frame_start and copy_done in the same cycle: copy_gnt drops, then RESUME follows once copy_req is low.
- Latency: frame_start to cpu_resume is 2 cycles when idle in WAITING with no copy pending (pending set, then RESUME).
- Counters saturate at 2^CNT_WIDTH-1 and never wrap. The watchdog counter is WDOG_WIDTH bits and is compared with ==.
- Reset mid-operation (reset_n low in any state): immediate return to HOLD, copy_gnt=0 asynchronously. The copy engine must abandon its transfer.
- state_o encoding: HOLD=0, RUN=1, WAITING=2, RESUME=3.

Decomposition:
- Shared package (constants.svh): sched_state_t enum for the four states and their encodings; reuse the existing `WAIT opcode macro; no new opcode constants.
- One natural sub-module: sat_counter (parameterised width, inc, saturating), instantiated twice for overrun_cnt and wdog_cnt.
- FSM, hold counter and watchdog stay in the top module.

Test Plan:
- Power-up: reset_n low 3 cycles, then high -> cpu_reset high exactly 4 cycles after release, state RUN, all counters 0.
- Normal frame: drive WAIT (0x????, opcode `WAIT) on instruction in RUN -> WAITING next cycle; frame_start pulse -> cpu_resume high exactly 1 cycle, 2 cycles after frame_start, then RUN.
- Copy window: in WAITING assert copy_req -> copy_gnt next cycle, mem_addr follows copy_mem_addr (drive 0x123 -> 0x123). Pulse frame_start mid-copy -> no resume until copy_done and copy_req low; resume 1 cycle after.
- Overrun: frame_start twice while in RUN -> overrun=1, overrun_cnt=2. The subsequent WAIT resumes immediately: cpu_resume 1 cycle after WAITING entry.
- Watchdog: WDOG_LIMIT=16, no WAIT for 16 RUN cycles -> HOLD, cpu_reset 4 cycles, wdog_cnt=1. Force 255 extra trips with CNT_WIDTH=8 -> wdog_cnt stays 255.
- Async reset mid-copy: reset_n low while copy_gnt=1 -> copy_gnt and cpu_resume 0 with no clock edge, cpu_reset 1, overrun cleared.
